// File: rtl/saturn_bus_pkg.sv
// Shared encodings for the Saturn nibble-ROM arbiter: default widths,
// burst-owner codes and the arbiter FSM state encoding.
package saturn_bus_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DT = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/saturn_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, remembers the last
// winner so a tie goes to the requester that was not served last.
module saturn_rr_arb2
    import saturn_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_if,
    input  logic req_dt,
    output logic gnt_if,
    output logic gnt_dt
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        gnt_if = 1'b0;
        gnt_dt = 1'b0;
        last_d = last_q;
        if (en) begin
            if (req_if && req_dt) begin
                if (last_q == OWN_DT) gnt_if = 1'b1;
                else                  gnt_dt = 1'b1;
            end else if (req_if) begin
                gnt_if = 1'b1;
            end else if (req_dt) begin
                gnt_dt = 1'b1;
            end
            if (gnt_if)      last_d = OWN_IF;
            else if (gnt_dt) last_d = OWN_DT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= OWN_DT;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/saturn_rom_arbiter.sv
// Arbitrates instruction-fetch and data-read nibble bursts onto a single
// registered nibble ROM; returns each nibble two cycles after its issue slot.
module saturn_rom_arbiter
    import saturn_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [LEN_W-1:0]  if_len,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [3:0]        if_data,
    output logic              if_last,

    input  logic              dt_req,
    input  logic [ADDR_W-1:0] dt_addr,
    input  logic [LEN_W-1:0]  dt_len,
    output logic              dt_gnt,
    output logic              dt_valid,
    output logic [3:0]        dt_data,
    output logic              dt_last,

    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_enable,
    input  logic [3:0]        rom_nibble,

    output logic              busy
);

    state_e            state_q,      state_d;
    owner_e            owner_q,      owner_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [LEN_W-1:0]  len_q,        len_d;
    logic [LEN_W-1:0]  cnt_q,        cnt_d;
    logic              rom_enable_q, rom_enable_d;
    logic              busy_q,       busy_d;

    logic              vld_p1_q,     vld_p1_d;
    owner_e            own_p1_q,     own_p1_d;
    logic              last_p1_q,    last_p1_d;

    logic              gnt_if_w;
    logic              gnt_dt_w;
    logic              arb_en;

    // Grants are only offered from IDLE and never while reset is high.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    saturn_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .req_if (if_req),
        .req_dt (dt_req),
        .gnt_if (gnt_if_w),
        .gnt_dt (gnt_dt_w)
    );

    // Stage p0: burst sequencing, one ROM address per BURST cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        rom_enable_d = rom_enable_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_if_w || gnt_dt_w) begin
                    owner_d      = gnt_dt_w ? OWN_DT : OWN_IF;
                    addr_d       = gnt_dt_w ? dt_addr : if_addr;
                    len_d        = gnt_dt_w ? dt_len : if_len;
                    cnt_d        = '0;
                    rom_enable_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (cnt_q == len_q) begin
                    rom_enable_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + LEN_W'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                rom_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // Stage p1: tag travelling with the ROM's registered read.
    always_comb begin
        vld_p1_d  = rom_enable_q;
        own_p1_d  = owner_q;
        last_p1_d = rom_enable_q && (cnt_q == len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rom_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            vld_p1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rom_enable_q <= rom_enable_d;
            busy_q       <= busy_d;
            vld_p1_q     <= vld_p1_d;
        end
        owner_q   <= owner_d;
        len_q     <= len_d;
        cnt_q     <= cnt_d;
        own_p1_q  <= own_p1_d;
        last_p1_q <= last_p1_d;
    end

    // Stage p2: nibble returned by the ROM, steered to the burst owner.
    assign rom_address = addr_q;
    assign rom_enable  = rom_enable_q;
    assign busy        = busy_q;

    assign if_gnt   = gnt_if_w;
    assign dt_gnt   = gnt_dt_w;

    assign if_valid = !reset && vld_p1_q && (own_p1_q == OWN_IF);
    assign dt_valid = !reset && vld_p1_q && (own_p1_q == OWN_DT);
    assign if_last  = if_valid && last_p1_q;
    assign dt_last  = dt_valid && last_p1_q;
    assign if_data  = if_valid ? rom_nibble : 4'h0;
    assign dt_data  = dt_valid ? rom_nibble : 4'h0;

endmodule

// File: tb/tb_saturn_rom_arbiter.sv
// Directed bench for saturn_rom_arbiter with a nibble ROM returning a[3:0].
module tb_saturn_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [19:0] if_addr;
    logic [3:0]  if_len;
    logic        if_gnt, if_valid, if_last;
    logic [3:0]  if_data;
    logic        dt_req;
    logic [19:0] dt_addr;
    logic [3:0]  dt_len;
    logic        dt_gnt, dt_valid, dt_last;
    logic [3:0]  dt_data;
    logic [19:0] rom_address;
    logic        rom_enable;
    logic [3:0]  rom_nibble;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    saturn_rom_arbiter #(.ADDR_W(20), .LEN_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_len      (if_len),
        .if_gnt      (if_gnt),
        .if_valid    (if_valid),
        .if_data     (if_data),
        .if_last     (if_last),
        .dt_req      (dt_req),
        .dt_addr     (dt_addr),
        .dt_len      (dt_len),
        .dt_gnt      (dt_gnt),
        .dt_valid    (dt_valid),
        .dt_data     (dt_data),
        .dt_last     (dt_last),
        .rom_address (rom_address),
        .rom_enable  (rom_enable),
        .rom_nibble  (rom_nibble),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: nibble(a) = a[3:0], registered on an enabled edge.
    initial rom_nibble = 4'h0;
    always @(posedge clk) if (rom_enable) rom_nibble <= rom_address[3:0];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b1;
        dt_req = 1'b1;
        @(negedge clk);
        check_eq("rst_if_gnt", if_gnt, 0);
        check_eq("rst_dt_gnt", dt_gnt, 0);
        check_eq("rst_if_valid", if_valid, 0);
        check_eq("rst_dt_valid", dt_valid, 0);
        next_cycle();
        next_cycle();
        reset  = 1'b0;
        if_req = 1'b0;
        dt_req = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rom_enable", rom_enable, 0);
        check_eq("rst_rom_address", rom_address, 0);
        next_cycle();
    endtask

    // Single burst from one requester; cycle 0 is the grant cycle.
    task automatic run_burst(input bit use_dt, input logic [19:0] a, input logic [3:0] l);
        logic [19:0] ea;
        logic [3:0]  ed;
        bit          ev, el;
        if (use_dt) begin
            dt_req = 1'b1; dt_addr = a; dt_len = l;
        end else begin
            if_req = 1'b1; if_addr = a; if_len = l;
        end
        @(negedge clk);
        check_eq("gnt_if", if_gnt, use_dt ? 0 : 1);
        check_eq("gnt_dt", dt_gnt, use_dt ? 1 : 0);
        check_eq("busy_c0", busy, 0);
        next_cycle();
        if_req = 1'b0;
        dt_req = 1'b0;
        for (int c = 1; c <= int'(l) + 3; c++) begin
            @(negedge clk);
            ev = (c >= 2) && (c <= int'(l) + 2);
            el = (c == int'(l) + 2);
            ea = a + 20'(c - 1);
            ed = ev ? 4'(a[3:0] + 4'(c - 2)) : 4'h0;
            check_eq("busy", busy, (c <= int'(l) + 1) ? 1 : 0);
            check_eq("rom_enable", rom_enable, (c <= int'(l) + 1) ? 1 : 0);
            if (c <= int'(l) + 1) check_eq("rom_address", rom_address, ea);
            check_eq("if_valid", if_valid, (ev && !use_dt) ? 1 : 0);
            check_eq("dt_valid", dt_valid, (ev && use_dt) ? 1 : 0);
            check_eq("if_data", if_data, use_dt ? 4'h0 : ed);
            check_eq("dt_data", dt_data, use_dt ? ed : 4'h0);
            check_eq("if_last", if_last, (el && !use_dt) ? 1 : 0);
            check_eq("dt_last", dt_last, (el && use_dt) ? 1 : 0);
            next_cycle();
        end
    endtask

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0; if_addr = '0; if_len = '0;
        dt_req  = 1'b0; dt_addr = '0; dt_len = '0;
        next_cycle();
        do_reset();

        run_burst(1'b0, 20'h00000, 4'h0);
        run_burst(1'b1, 20'h00123, 4'h4);
        run_burst(1'b0, 20'hFFFFE, 4'h3);

        // Round-robin alternation with both requesters held.
        do_reset();
        if_req = 1'b1; if_addr = 20'h00040; if_len = 4'h0;
        dt_req = 1'b1; dt_addr = 20'h00051; dt_len = 4'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("alt_if_gnt", if_gnt, (c % 4 == 0) ? 1 : 0);
            check_eq("alt_dt_gnt", dt_gnt, (c % 4 == 2) ? 1 : 0);
            if (c >= 2 && c % 2 == 0) begin
                check_eq("alt_if_valid", if_valid, ((c - 2) % 4 == 0) ? 1 : 0);
                check_eq("alt_dt_valid", dt_valid, ((c - 2) % 4 == 2) ? 1 : 0);
                check_eq("alt_data", if_data | dt_data, ((c - 2) % 4 == 0) ? 4'h0 : 4'h1);
            end
            next_cycle();
        end
        if_req = 1'b0;
        dt_req = 1'b0;
        next_cycle();
        next_cycle();

        // Long if burst; dt request waits for the IDLE cycle carrying if_last.
        if_req = 1'b1; if_addr = 20'h00010; if_len = 4'hF;
        for (int c = 0; c <= 18; c++) begin
            if (c == 1) if_req = 1'b0;
            if (c == 3) begin dt_req = 1'b1; dt_addr = 20'h00005; dt_len = 4'h0; end
            if (c == 18) dt_req = 1'b0;
            @(negedge clk);
            if (c == 0) check_eq("long_if_gnt", if_gnt, 1);
            if (c >= 1 && c <= 16) begin
                check_eq("long_dt_gnt_blocked", dt_gnt, 0);
                check_eq("long_busy", busy, 1);
            end
            if (c == 17) begin
                check_eq("long_dt_gnt", dt_gnt, 1);
                check_eq("long_if_last", if_last, 1);
                check_eq("long_if_valid", if_valid, 1);
                check_eq("long_if_data", if_data, 4'hF);
                check_eq("long_busy_idle", busy, 0);
            end
            if (c == 18) begin
                check_eq("b2b_rom_address", rom_address, 20'h00005);
                check_eq("b2b_rom_enable", rom_enable, 1);
                check_eq("b2b_dt_gnt", dt_gnt, 0);
            end
            next_cycle();
        end
        @(negedge clk);
        check_eq("b2b_dt_valid", dt_valid, 1);
        check_eq("b2b_dt_data", dt_data, 4'h5);
        check_eq("b2b_dt_last", dt_last, 1);
        next_cycle();
        @(negedge clk);
        check_eq("b2b_dt_valid_end", dt_valid, 0);
        next_cycle();

        // Reset pulsed in cycle 5 of a 16-nibble burst.
        if_req = 1'b1; if_addr = 20'h00020; if_len = 4'hF;
        for (int c = 0; c <= 8; c++) begin
            if (c == 1) if_req = 1'b0;
            reset = (c == 5);
            @(negedge clk);
            if (c == 3) begin
                check_eq("mid_if_valid", if_valid, 1);
                check_eq("mid_if_data", if_data, 4'h1);
            end
            if (c == 5) begin
                check_eq("mid_rst_if_valid", if_valid, 0);
                check_eq("mid_rst_if_data", if_data, 4'h0);
            end
            if (c >= 6) begin
                check_eq("post_rst_rom_enable", rom_enable, 0);
                check_eq("post_rst_busy", busy, 0);
                check_eq("post_rst_if_valid", if_valid, 0);
            end
            next_cycle();
        end
        reset = 1'b0;
        run_burst(1'b0, 20'h00031, 4'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/saturn_rom_arbiter.md
SATURN_ROM_ARBITER -- requirements
Module: saturn_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, nibble address width.
REQ-002 SHALL have parameter LEN_W, default 4, burst length field width (count minus one).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W, if_len in LEN_W: instruction-fetch burst request, start nibble address, nibble count minus one.
REQ-006 SHALL have ports if_gnt out 1, if_valid out 1, if_data out 4, if_last out 1: request accept, nibble strobe, nibble, final nibble of burst.
REQ-007 SHALL have ports dt_req, dt_addr, dt_len, dt_gnt, dt_valid, dt_data, dt_last: same widths and meanings for the data-read (D0/D1) requester.
REQ-008 SHALL have ports rom_address out ADDR_W, rom_enable out 1, rom_nibble in 4: nibble ROM port; ROM registers rom_nibble on the edge where rom_enable=1.
REQ-009 SHALL have port busy out 1, high while a burst is being issued.

Function
REQ-010 SHALL implement FSM states IDLE and BURST only.
REQ-011 SHALL, in IDLE, assert exactly one gnt combinationally in the same cycle as the selected req; no gnt in BURST.
REQ-012 SHALL, on a single req in IDLE, grant that requester.
REQ-013 SHALL, on simultaneous reqs in IDLE, grant the requester not granted last (round-robin); last-owner resets to dt, so if wins the first tie.
REQ-014 SHALL, on the grant edge, latch owner, address and length, load rom_address=addr and rom_enable=1, and enter BURST.
REQ-015 SHALL, in BURST, present one address per cycle, incrementing modulo 2^ADDR_W (0xFFFFF wraps to 0x00000).
REQ-016 SHALL issue exactly len+1 addresses (len=0 -> 1 nibble, len=0xF -> 16), then deassert rom_enable and return to IDLE on the edge after the last issue.
REQ-017 SHALL deliver nibble k of the burst (k=0..len) on the owner's valid/data in cycle G+2+k, G being the grant cycle.
REQ-018 SHALL assert owner's last together with valid for nibble len only.
REQ-019 SHALL drive non-owner valid/last/data to 0; data SHALL be 0 whenever valid=0.
REQ-020 SHALL permit a new grant in the IDLE cycle that carries the previous burst's last nibble (back-to-back, no bubble on rom_enable beyond that IDLE cycle).
REQ-021 SHALL ignore req changes and addr/len values during BURST; requester SHALL drop req after gnt (req held is treated as a new request).
REQ-022 SHALL drive busy=1 exactly while in BURST.

Reset
REQ-023 SHALL, on reset asserted at any edge, including mid-burst, force IDLE, rom_enable=0, rom_address=0, busy=0, last-owner=dt, and cancel the pipeline so no valid asserts in the following cycle.
REQ-024 SHALL hold all gnt, valid, last and data outputs at 0 while reset is high.

Structure
REQ-025 SHALL place ADDR_W, LEN_W defaults, owner encoding (OWN_IF, OWN_DT) and the FSM state encoding in shared package saturn_bus_pkg.
REQ-026 SHALL implement the two-way round-robin priority logic as sub-module saturn_rr_arb2; the rest is flat.

Verification (ROM model preloaded with nibble(a)=a[3:0])
REQ-027 SHALL cover: reset, if_req addr=0x00000 len=0 -> if_gnt cycle 0; if_valid=1, if_data=0x0, if_last=1 cycle 2; busy cycle 1 only.
REQ-028 SHALL cover: dt_req addr=0x00123 len=4 -> dt_data 3,4,5,6,7 cycles 2..6; dt_last cycle 6 only; if_valid stays 0.
REQ-029 SHALL cover: after reset both req every IDLE cycle, len=0 -> grants alternate if, dt, if, dt.
REQ-030 SHALL cover: if_req addr=0xFFFFE len=3 -> rom_address FFFFE, FFFFF, 00000, 00001; data E, F, 0, 1.
REQ-031 SHALL cover: if burst len=0xF, dt_req raised cycle 3 -> no dt_gnt until cycle 17 (IDLE); dt_gnt=1 then, alongside if_last.
REQ-032 SHALL cover: reset pulsed cycle 5 of 16-nibble burst -> cycle 6 onward rom_enable=0, busy=0, no valid; next if_req granted and served normally.
